// File: rtl/dvi_video_timing.sv
// Pixel-clock raster timing generator that locks a ready/valid RGB888 stream to the raster origin
// and emits de, per-channel pixel data and sync control words for a downstream DVI/TMDS encoder.
module dvi_video_timing #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int H_POL    = 1,
    parameter int V_POL    = 1
) (
    input  logic        clk_pix,
    input  logic        rst_pix_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [23:0] s_data,
    input  logic        s_first,
    output logic        de,
    output logic [7:0]  data_in_ch0,
    output logic [7:0]  data_in_ch1,
    output logic [7:0]  data_in_ch2,
    output logic [1:0]  ctrl_in_ch0,
    output logic [1:0]  ctrl_in_ch1,
    output logic [1:0]  ctrl_in_ch2,
    output logic        frame_start,
    output logic [15:0] underflow_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HP       = 1'(H_POL);
    localparam logic          VP       = 1'(V_POL);

    typedef enum logic {ALIGN, RUN} state_t;

    state_t         state_q;
    logic [HW-1:0]  hcnt_q, hcnt_d;
    logic [VW-1:0]  vcnt_q, vcnt_d;
    logic           de_q;
    logic [23:0]    data_q;
    logic [1:0]     ctrl_q;
    logic           frame_start_q;
    logic [15:0]    count_q;

    logic active, origin, hsync_on, vsync_on;
    logic lock, take, fault, ready_int;

    always_comb begin
        active   = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        origin   = (hcnt_q == '0) && (vcnt_q == '0);
        hsync_on = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
        vsync_on = (vcnt_q >= VS_START) && (vcnt_q < VS_END);

        // ALIGN only leaves via a frame marker presented exactly at the raster origin.
        lock  = (state_q == ALIGN) && origin && s_valid && s_first;
        take  = (state_q == RUN) && active && s_valid && (!s_first || origin);
        fault = (state_q == RUN) && active && (!s_valid || (s_first && !origin));

        // A misplaced frame marker is refused so the same beat can relock at the next origin.
        if (state_q == ALIGN) begin
            ready_int = s_valid && (!s_first || origin);
        end else begin
            ready_int = active && !(s_valid && s_first && !origin);
        end

        hcnt_d = hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        end
    end

    assign s_ready = rst_pix_n && ready_int;

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state_q       <= ALIGN;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            de_q          <= 1'b0;
            data_q        <= '0;
            ctrl_q        <= {~VP, ~HP};
            frame_start_q <= 1'b0;
            count_q       <= '0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            de_q          <= active;
            data_q        <= (lock || take) ? s_data : '0;
            ctrl_q        <= {vsync_on ? VP : ~VP, hsync_on ? HP : ~HP};
            frame_start_q <= origin;
            if (fault && (count_q != 16'hFFFF)) begin
                count_q <= count_q + 16'd1;
            end
            if (lock) begin
                state_q <= RUN;
            end else if (fault) begin
                state_q <= ALIGN;
            end
        end
    end

    assign de              = de_q;
    assign data_in_ch0     = data_q[7:0];
    assign data_in_ch1     = data_q[15:8];
    assign data_in_ch2     = data_q[23:16];
    assign ctrl_in_ch0     = ctrl_q;
    assign ctrl_in_ch1     = 2'b00;
    assign ctrl_in_ch2     = 2'b00;
    assign frame_start     = frame_start_q;
    assign underflow_count = count_q;

endmodule
